popcount_seq: RTL
=================

Name: popcount_seq

Overview:
- Multi-cycle, parametrised population-count / Hamming-distance unit; successor to the combinational 32-bit popcount block.
- Processes one CHUNK-bit slice per cycle, so the adder depth per cycle stays small.
- Ready/valid handshake on both sides.
- Sits beside the ALU as a slow-path functional unit for bit-count and bit-difference instructions.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits counted per cycle; 1 <= CHUNK <= WIDTH.
NCH (local), WIDTH/CHUNK, number of RUN cycles.
CW (local), $clog2(WIDTH+1), result width; 6 for WIDTH=32.

Ports:
clk        input   1      clock; all state changes on rising edge
rst        input   1      synchronous, active-high reset
in_valid   input   1      operand request valid
in_ready   output  1      unit can accept a request
mode       input   1      0 = popcount(a); 1 = Hamming distance popcount(a ^ b)
a          input   WIDTH  operand A
b          input   WIDTH  operand B; ignored when mode=0
out_valid  output  1      result valid
out_ready  input   1      consumer accepts result
count      output  CW     number of set bits
parity     output  1      count[0], i.e. XOR-reduction of the counted operand
zero       output  1      count == 0

Behaviour:
- Reset: one clock, synchronous, active-high. rst=1 at a rising edge forces:
  - state=IDLE; in_ready=1; out_valid=0; count=0; parity=0; zero=1.
  - Internal operand register, accumulator and slice index are cleared.
  - rst has priority over every other input.
- Reset mid-operation: RUN or DONE is aborted and no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On edge with in_valid=1: latch op = mode ? (a ^ b) : a. Clear acc and idx. Go to RUN.
  - in_valid=0: remain in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: acc <= acc + popcount(op[idx*CHUNK +: CHUNK]); idx <= idx+1.
  - On the edge that processes idx == NCH-1: go to DONE.
  - Exactly NCH RUN cycles.
- DONE:
  - out_valid=1; count=acc, parity=acc[0], zero=(acc==0), all driven from registered acc.
  - Outputs are held stable while out_ready=0, for any number of cycles.
  - On edge with out_ready=1: go to IDLE.
  - in_ready=0 throughout DONE; no same-cycle re-accept.
- Latency: request accepted at edge E → out_valid=1 in the cycle after edge E+NCH. This is 4 cycles for the defaults.
- Throughput: at most one result per NCH+2 cycles.
- Width rules:
  - acc is CW bits wide and cannot overflow; max value is WIDTH.
  - Per-slice count is $clog2(CHUNK+1) bits, zero-extended before the add.
- Operand isolation: a, b and mode changes after acceptance do not affect the in-flight result. in_valid during RUN/DONE is ignored; the request is not queued.
- Outputs count/parity/zero outside DONE keep the last result; they are only meaningful while out_valid=1.
- Illegal parameters (WIDTH % CHUNK != 0): elaboration-time error via generate-time check.

Test Plan:
- Defaults, mode=0, a=32'hAAAAAAAA, in_valid pulse, out_ready=1 → out_valid rises 4 cycles after acceptance; count=16, parity=0, zero=0; IDLE next cycle.
- mode=1, a=32'hFFFFFFFF, b=32'h00000000 → count=32 (6'b100000), parity=0. Then a=b=32'h12345678 → count=0, zero=1.
- Backpressure: a=32'h0000000F, mode=0, out_ready=0 for 6 cycles after out_valid → count=4 held, out_valid held, in_ready=0. Release → IDLE, in_ready=1.
- Operand isolation: change a to 32'hFFFFFFFF and pulse in_valid during RUN of a request with a=32'h1 → result count=1, parity=1; second request not accepted.
- Reset mid-RUN: assert rst on 2nd RUN cycle → next cycle IDLE, out_valid=0, count=0, zero=1. Next request a=32'h80000001 → count=2.
- Parameter sweep:
  - WIDTH=64, CHUNK=16, a=all ones → count=64 (7 bits) after 4 RUN cycles.
  - WIDTH=8, CHUNK=1, a=8'hB5 → count=5 after 8 RUN cycles.

Source files
------------

// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population count / Hamming distance unit.
// Counts one CHUNK-bit slice of the latched operand per cycle and presents
// the total with parity and zero flags through a ready/valid output.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand request valid
//   in_ready   out  unit can accept a request (IDLE only)
//   mode       in   0 = popcount(a), 1 = popcount(a ^ b)
//   a, b       in   WIDTH-bit operands (b ignored when mode=0)
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts the result
//   count      out  CW-bit number of set bits
//   parity     out  count[0]
//   zero       out  count == 0
module popcount_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       parity,
  output logic                       zero
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned SW  = $clog2(CHUNK + 1);
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  // Reject parameter sets that do not tile the operand into whole slices
  generate
    if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("popcount_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_op,        w_op_nxt;
  logic [CW-1:0]    r_acc,       w_acc_nxt;
  logic [IW-1:0]    r_idx,       w_idx_nxt;
  logic [CW-1:0]    r_count,     w_count_nxt;
  logic             r_parity,    w_parity_nxt;
  logic             r_zero,      w_zero_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;

  logic [CHUNK-1:0] w_slice;
  logic [SW-1:0]    w_slice_cnt;

  // Current slice and its bit count
  always_comb begin
    w_slice     = CHUNK'(r_op >> (int'(r_idx) * CHUNK));
    w_slice_cnt = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      w_slice_cnt = w_slice_cnt + SW'(w_slice[i]);
    end
  end

  // Next-state and next-register values
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_acc_nxt    = r_acc;
    w_idx_nxt    = r_idx;
    w_count_nxt  = r_count;
    w_parity_nxt = r_parity;
    w_zero_nxt   = r_zero;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_RUN;
          w_op_nxt    = mode ? (a ^ b) : a;
          w_acc_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_RUN: begin
        w_acc_nxt = r_acc + CW'(w_slice_cnt);
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          // Result registers only change here, so they hold the last
          // result through IDLE and RUN of the following request.
          w_state_nxt  = S_DONE;
          w_count_nxt  = w_acc_nxt;
          w_parity_nxt = w_acc_nxt[0];
          w_zero_nxt   = (w_acc_nxt == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_parity    <= 1'b0;
      r_zero      <= 1'b1;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_acc       <= w_acc_nxt;
      r_idx       <= w_idx_nxt;
      r_count     <= w_count_nxt;
      r_parity    <= w_parity_nxt;
      r_zero      <= w_zero_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign parity    = r_parity;
  assign zero      = r_zero;

endmodule
